// File: rtl/layer_compositor_pkg.sv
// Shared types and reset-time constants for the layer compositor.
// Each palette entry is {R,G,B}. Entry i occupies bits [i*3*COLOR_W +: 3*COLOR_W], and the last entry is the background.
package layer_compositor_pkg;

    localparam int COLOR_W        = 4;
    localparam int NUM_LAYERS_DEF = 8;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        FLASH_IDLE = 2'd0,
        FLASH_ON   = 2'd1,
        FLASH_OFF  = 2'd2
    } flash_state_t;

    // Entries from the background (entry 8) down to layer 0. Layer order is:
    // collider, trigger, border, player, HUD border, health, character, spare.
    localparam logic [(NUM_LAYERS_DEF+1)*3*COLOR_W-1:0] DEFAULT_PALETTE = {
        12'h000, 12'h000, 12'h0F0, 12'hFA8, 12'hFFF,
        12'h00F, 12'hFFF, 12'hF00, 12'h0FF
    };

endpackage

// File: rtl/layer_compositor_flash_ctrl.sv
// Frame-counted damage-flash sequencer: ON/OFF half-cycles of FLASH_PERIOD frames, FLASH_COUNT pairs.
module layer_compositor_flash_ctrl #(
    parameter int NUM_LAYERS   = 8,
    parameter int FLASH_PERIOD = 4,
    parameter int FLASH_COUNT  = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          frame_start,
    input  logic                          flash_req,
    input  logic [$clog2(NUM_LAYERS)-1:0] flash_layer,
    output logic                          flash_on,
    output logic                          flash_active,
    output logic [$clog2(NUM_LAYERS)-1:0] flash_idx
);
    import layer_compositor_pkg::*;

    localparam int FC_W  = $clog2(FLASH_PERIOD + 1);
    localparam int PC_W  = $clog2(FLASH_COUNT + 1);
    localparam int IDX_W = $clog2(NUM_LAYERS);

    flash_state_t     state_r, state_s;
    logic [FC_W-1:0]  frame_cnt_r, frame_cnt_s;
    logic [PC_W-1:0]  pair_cnt_r, pair_cnt_s;
    logic [IDX_W-1:0] idx_r, idx_s;
    logic             period_end_s;

    assign period_end_s = (frame_cnt_r == FC_W'(FLASH_PERIOD - 1));
    assign flash_on     = (state_r == FLASH_ON);
    assign flash_active = (state_r != FLASH_IDLE);
    assign flash_idx    = idx_r;

    // State, counter and latched-layer registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= FLASH_IDLE;
            frame_cnt_r <= '0;
            pair_cnt_r  <= '0;
            idx_r       <= '0;
        end else begin
            state_r     <= state_s;
            frame_cnt_r <= frame_cnt_s;
            pair_cnt_r  <= pair_cnt_s;
            idx_r       <= idx_s;
        end
    end

    // Next state: a request always restarts and swallows a coincident frame_start
    always_comb begin
        state_s     = state_r;
        frame_cnt_s = frame_cnt_r;
        pair_cnt_s  = pair_cnt_r;
        idx_s       = idx_r;
        if (flash_req) begin
            state_s     = FLASH_ON;
            frame_cnt_s = '0;
            pair_cnt_s  = '0;
            idx_s       = flash_layer;
        end else if (frame_start) begin
            case (state_r)
                FLASH_ON: begin
                    if (period_end_s) begin
                        state_s     = FLASH_OFF;
                        frame_cnt_s = '0;
                    end else begin
                        frame_cnt_s = frame_cnt_r + FC_W'(1);
                    end
                end
                FLASH_OFF: begin
                    if (period_end_s) begin
                        frame_cnt_s = '0;
                        if (pair_cnt_r == PC_W'(FLASH_COUNT - 1)) begin
                            state_s = FLASH_IDLE;
                        end else begin
                            state_s    = FLASH_ON;
                            pair_cnt_s = pair_cnt_r + PC_W'(1);
                        end
                    end else begin
                        frame_cnt_s = frame_cnt_r + FC_W'(1);
                    end
                end
                FLASH_IDLE: state_s = FLASH_IDLE;
                default:    state_s = FLASH_IDLE;
            endcase
        end else begin
            state_s = state_r;
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// Two-stage priority layer compositor with a writable palette, clip mask and damage flash.
// Optional background tint: define LAYER_COMPOSITOR_BG_TINT_EN.
module layer_compositor #(
    parameter int                                   NUM_LAYERS      = 8,
    parameter int                                   COLOR_W         = layer_compositor_pkg::COLOR_W,
    parameter logic [NUM_LAYERS-1:0]                CLIP_MASK       = 8'b0000_0011,
    parameter logic [(NUM_LAYERS+1)*3*COLOR_W-1:0]  DEFAULT_PALETTE = layer_compositor_pkg::DEFAULT_PALETTE,
    parameter int                                   FLASH_PERIOD    = 4,
    parameter int                                   FLASH_COUNT     = 3
`ifdef LAYER_COMPOSITOR_BG_TINT_EN
    ,
    parameter logic [3*COLOR_W-1:0]                 TINT_COLOR      = 12'h444
`endif
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              pix_en,
    input  logic                              frame_start,
    input  logic [NUM_LAYERS-1:0]             layer_hit,
    input  logic [NUM_LAYERS-1:0]             layer_en,
    input  logic                              blank,
    input  logic                              outside,
    input  logic                              transparent_outside,
    input  logic                              cfg_we,
    input  logic [$clog2(NUM_LAYERS+1)-1:0]   cfg_addr,
    input  logic [3*COLOR_W-1:0]              cfg_data,
    input  logic                              flash_req,
    input  logic [$clog2(NUM_LAYERS)-1:0]     flash_layer,
`ifdef LAYER_COMPOSITOR_BG_TINT_EN
    input  logic                              bg_tint,
`endif
    output logic                              flash_active,
    output logic [COLOR_W-1:0]                red,
    output logic [COLOR_W-1:0]                green,
    output logic [COLOR_W-1:0]                blue
);
    import layer_compositor_pkg::*;

    localparam int RGB_W  = 3 * COLOR_W;
    localparam int SEL_W  = $clog2(NUM_LAYERS);
    localparam int ADDR_W = $clog2(NUM_LAYERS + 1);

    logic [NUM_LAYERS-1:0] eff_s;
    logic                  clip_s;
    logic [SEL_W-1:0]      sel_s;
    logic                  valid_r, blank_r, any_r;
    logic [SEL_W-1:0]      sel_r;
    logic [RGB_W-1:0]      palette_r [NUM_LAYERS+1];
    logic [RGB_W-1:0]      rgb_s, rgb_r;
    logic                  flash_on_s;
    logic [SEL_W-1:0]      flash_idx_s;
`ifdef LAYER_COMPOSITOR_BG_TINT_EN
    logic                  tint_r;
`endif

    layer_compositor_flash_ctrl #(
        .NUM_LAYERS   (NUM_LAYERS),
        .FLASH_PERIOD (FLASH_PERIOD),
        .FLASH_COUNT  (FLASH_COUNT)
    ) u_flash (
        .clk          (clk),
        .reset        (reset),
        .frame_start  (frame_start),
        .flash_req    (flash_req),
        .flash_layer  (flash_layer),
        .flash_on     (flash_on_s),
        .flash_active (flash_active),
        .flash_idx    (flash_idx_s)
    );

    assign clip_s = outside & ~transparent_outside;
    assign eff_s  = layer_hit & layer_en & ~(CLIP_MASK & {NUM_LAYERS{clip_s}});

    // Priority encoder: the lowest set index wins
    always_comb begin
        sel_s = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (eff_s[i]) begin
                sel_s = SEL_W'(i);
            end else begin
                sel_s = sel_s;
            end
        end
    end

    // Stage 1 registers; valid_r keeps the slot that was in flight at reset black
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_r <= 1'b0;
            blank_r <= 1'b0;
            any_r   <= 1'b0;
            sel_r   <= '0;
`ifdef LAYER_COMPOSITOR_BG_TINT_EN
            tint_r  <= 1'b0;
`endif
        end else if (pix_en) begin
            valid_r <= 1'b1;
            blank_r <= blank;
            any_r   <= |eff_s;
            sel_r   <= sel_s;
`ifdef LAYER_COMPOSITOR_BG_TINT_EN
            tint_r  <= bg_tint;
`endif
        end
    end

    // Palette storage; a write lands on the edge, so a lookup on that edge still reads the old entry
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i <= NUM_LAYERS; i++) begin
                palette_r[i] <= DEFAULT_PALETTE[i*RGB_W +: RGB_W];
            end
        end else if (cfg_we && (cfg_addr <= ADDR_W'(NUM_LAYERS))) begin
            palette_r[cfg_addr] <= cfg_data;
        end
    end

    // Stage 2 colour selection
    always_comb begin
        rgb_s = '0;
        if (!valid_r || blank_r) begin
            rgb_s = '0;
        end else if (!any_r) begin
`ifdef LAYER_COMPOSITOR_BG_TINT_EN
            if (tint_r) begin
                rgb_s = TINT_COLOR;
            end else begin
                rgb_s = palette_r[ADDR_W'(NUM_LAYERS)];
            end
`else
            rgb_s = palette_r[ADDR_W'(NUM_LAYERS)];
`endif
        end else if (flash_on_s && (sel_r == flash_idx_s)) begin
            rgb_s = '1;
        end else begin
            rgb_s = palette_r[ADDR_W'(sel_r)];
        end
    end

    // Stage 2 output register, held between pixel ticks
    always_ff @(posedge clk) begin
        if (!reset) begin
            rgb_r <= '0;
        end else if (pix_en) begin
            rgb_r <= rgb_s;
        end
    end

    assign red   = rgb_r[RGB_W-1 -: COLOR_W];
    assign green = rgb_r[2*COLOR_W-1 -: COLOR_W];
    assign blue  = rgb_r[COLOR_W-1:0];

endmodule

// File: tb/tb_layer_compositor.sv
// Self-checking bench for layer_compositor: vector table, flash/reset sequences and a randomized run against a behavioural model.
module tb_layer_compositor;

    localparam int P = 4;
    localparam int C = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, pix_en, frame_start, blank, outside, transparent_outside, cfg_we, flash_req;
    logic [7:0] layer_hit, layer_en;
    logic [3:0] cfg_addr;
    logic [11:0] cfg_data;
    logic [2:0] flash_layer;
    logic       flash_active;
    logic [3:0] red, green, blue;
`ifdef LAYER_COMPOSITOR_BG_TINT_EN
    logic       bg_tint;
`endif

    layer_compositor dut (
        .clk                 (clk),
        .reset               (reset),
        .pix_en              (pix_en),
        .frame_start         (frame_start),
        .layer_hit           (layer_hit),
        .layer_en            (layer_en),
        .blank               (blank),
        .outside             (outside),
        .transparent_outside (transparent_outside),
        .cfg_we              (cfg_we),
        .cfg_addr            (cfg_addr),
        .cfg_data            (cfg_data),
        .flash_req           (flash_req),
        .flash_layer         (flash_layer),
`ifdef LAYER_COMPOSITOR_BG_TINT_EN
        .bg_tint             (bg_tint),
`endif
        .flash_active        (flash_active),
        .red                 (red),
        .green               (green),
        .blue                (blue)
    );

    int checks = 0;
    int failures = 0;

    logic [11:0] pal_def [9] = '{12'h0FF, 12'hF00, 12'hFFF, 12'h00F, 12'hFFF,
                                 12'hFA8, 12'h0F0, 12'h000, 12'h000};
    logic [7:0]  clip_m = 8'b0000_0011;

    // Reference model: what is in flight, the palette, and frames elapsed since the last flash request
    logic [11:0] pal_m [9];
    bit          s1_valid, s1_blank, s1_tint;
    int          s1_win;
    logic [11:0] rgb_m;
    bit          fl_act;
    int          fl_n, fl_layer;

    typedef struct packed {
        logic [7:0]  hit;
        logic [7:0]  en;
        logic        blk;
        logic        out;
        logic        tr;
        logic [11:0] exp;
    } vec_t;
    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int winner();
        for (int i = 0; i < 8; i++) begin
            if (layer_hit[i] && layer_en[i] && !(clip_m[i] && outside && !transparent_outside))
                return i;
        end
        return -1;
    endfunction

    task automatic model_edge();
        if (pix_en) begin
            if (!s1_valid || s1_blank)
                rgb_m = 12'h000;
            else if (s1_win < 0)
                rgb_m = s1_tint ? 12'h444 : pal_m[8];
            else if (fl_act && ((fl_n / P) % 2 == 0) && fl_layer == s1_win)
                rgb_m = 12'hFFF;
            else
                rgb_m = pal_m[s1_win];
            s1_valid = 1'b1;
            s1_blank = blank;
            s1_win   = winner();
`ifdef LAYER_COMPOSITOR_BG_TINT_EN
            s1_tint  = bg_tint;
`else
            s1_tint  = 1'b0;
`endif
        end
        if (cfg_we && cfg_addr <= 4'd8)
            pal_m[cfg_addr] = cfg_data;
        if (flash_req) begin
            fl_act = 1'b1;
            fl_n = 0;
            fl_layer = int'(flash_layer);
        end else if (frame_start && fl_act) begin
            fl_n++;
            if (fl_n == 2 * P * C) fl_act = 1'b0;
        end
    endtask

    task automatic step(input bit pe, input bit fs, input bit fr);
        pix_en = pe;
        frame_start = fs;
        flash_req = fr;
        @(posedge clk);
        model_edge();
        #1;
        pix_en = 1'b0;
        frame_start = 1'b0;
        flash_req = 1'b0;
        cfg_we = 1'b0;
        check("flash_active", 32'(flash_active), 32'(fl_act));
        if (pe) check("rgb_model", 32'({red, green, blue}), 32'(rgb_m));
    endtask

    task automatic pixel();
        step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        check("rgb_hold", 32'({red, green, blue}), 32'(rgb_m));
    endtask

    task automatic set_px(input logic [7:0] hit, input logic [7:0] en, input logic blk,
                          input logic out, input logic tr);
        layer_hit = hit;
        layer_en = en;
        blank = blk;
        outside = out;
        transparent_outside = tr;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        pix_en = 1'b0;
        frame_start = 1'b0;
        flash_req = 1'b0;
        cfg_we = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 9; i++) pal_m[i] = pal_def[i];
        s1_valid = 1'b0;
        s1_blank = 1'b0;
        s1_tint = 1'b0;
        s1_win = -1;
        rgb_m = 12'h000;
        fl_act = 1'b0;
        fl_n = 0;
        check("reset_rgb", 32'({red, green, blue}), 32'h0);
        check("reset_flash_active", 32'(flash_active), 32'h0);
    endtask

    task automatic flash_frame(input int f, input bit is_start, input bit req, input logic [11:0] exp);
        if (is_start) step(1'b0, 1'b1, req);
        repeat (3) pixel();
        check($sformatf("flash_frame%0d", f), 32'({red, green, blue}), 32'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "bench timeout");
    end

    initial begin
        cfg_addr = 4'd0;
        cfg_data = 12'h000;
        flash_layer = 3'd0;
`ifdef LAYER_COMPOSITOR_BG_TINT_EN
        bg_tint = 1'b0;
`endif
        set_px(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        do_reset();

        vecs[0]  = '{8'h0C, 8'hFF, 1'b0, 1'b0, 1'b0, 12'hFFF};
        vecs[1]  = '{8'h0C, 8'hFF, 1'b1, 1'b0, 1'b0, 12'h000};
        vecs[2]  = '{8'h01, 8'hFF, 1'b0, 1'b1, 1'b0, 12'h000};
        vecs[3]  = '{8'h01, 8'hFF, 1'b0, 1'b1, 1'b1, 12'h0FF};
        vecs[4]  = '{8'h41, 8'hFF, 1'b0, 1'b1, 1'b0, 12'h0F0};
        vecs[5]  = '{8'h03, 8'hFE, 1'b0, 1'b0, 1'b0, 12'hF00};
        vecs[6]  = '{8'h20, 8'hFF, 1'b0, 1'b0, 1'b0, 12'hFA8};
        vecs[7]  = '{8'h18, 8'hFF, 1'b0, 1'b0, 1'b0, 12'h00F};
        vecs[8]  = '{8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 12'h000};
        vecs[9]  = '{8'h03, 8'hFF, 1'b0, 1'b1, 1'b1, 12'h0FF};
        vecs[10] = '{8'h80, 8'hFF, 1'b0, 1'b1, 1'b0, 12'h000};
        vecs[11] = '{8'h0C, 8'hF3, 1'b0, 1'b0, 1'b0, 12'h000};
        for (int i = 0; i < 12; i++) begin
            set_px(vecs[i].hit, vecs[i].en, vecs[i].blk, vecs[i].out, vecs[i].tr);
            pixel();
            pixel();
            check($sformatf("vec%0d", i), 32'({red, green, blue}), 32'(vecs[i].exp));
        end

        // Palette write on a pixel edge: that edge still shows the old colour
        set_px(8'h08, 8'hFF, 1'b0, 1'b0, 1'b0);
        pixel();
        pixel();
        cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = 12'hA50;
        step(1'b1, 1'b0, 1'b0);
        check("pal_same_edge_old", 32'({red, green, blue}), 32'h00F);
        pixel();
        check("pal_write", 32'({red, green, blue}), 32'hA50);
        cfg_we = 1'b1; cfg_addr = 4'd9; cfg_data = 12'h123;
        step(1'b0, 1'b0, 1'b0);
        set_px(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
        pixel(); pixel();
        check("pal_addr9_bg", 32'({red, green, blue}), 32'h000);
        set_px(8'h08, 8'hFF, 1'b0, 1'b0, 1'b0);
        pixel(); pixel();
        check("pal_addr9_l3", 32'({red, green, blue}), 32'hA50);

        // Full flash sequence on layer 3 after a palette reload
        do_reset();
        pixel(); pixel();
        check("reset_palette", 32'({red, green, blue}), 32'h00F);
        flash_layer = 3'd3;
        step(1'b0, 1'b0, 1'b1);
        for (int f = 0; f < 28; f++) begin
            flash_frame(f, f > 0, 1'b0, (f < 24 && ((f / 4) % 2 == 0)) ? 12'hFFF : 12'h00F);
            check($sformatf("flash_active_f%0d", f), 32'(flash_active), 32'(f < 24));
        end

        // Restart at frame 6 (coincident with frame_start), masking, then reset mid-flash
        step(1'b0, 1'b0, 1'b1);
        for (int f = 0; f < 6; f++)
            flash_frame(f, f > 0, 1'b0, ((f / 4) % 2 == 0) ? 12'hFFF : 12'h00F);
        flash_frame(6, 1'b1, 1'b1, 12'hFFF);
        set_px(8'h0A, 8'hFF, 1'b0, 1'b0, 1'b0);
        flash_frame(7, 1'b1, 1'b0, 12'hF00);
        set_px(8'h08, 8'hFF, 1'b0, 1'b0, 1'b0);
        flash_frame(8, 1'b1, 1'b0, 12'hFFF);
        flash_frame(9, 1'b1, 1'b0, 12'hFFF);
        step(1'b0, 1'b1, 1'b0);
        pixel();
        do_reset();
        set_px(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
        pixel();
        check("post_reset_black0", 32'({red, green, blue}), 32'h000);
        pixel();
        check("post_reset_black1", 32'({red, green, blue}), 32'h000);
        set_px(8'h08, 8'hFF, 1'b0, 1'b0, 1'b0);
        pixel(); pixel();
        check("post_reset_no_flash", 32'({red, green, blue}), 32'h00F);

`ifdef LAYER_COMPOSITOR_BG_TINT_EN
        bg_tint = 1'b1;
        set_px(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
        pixel(); pixel();
        check("tint_bg", 32'({red, green, blue}), 32'h444);
        set_px(8'h40, 8'hFF, 1'b0, 1'b0, 1'b0);
        pixel(); pixel();
        check("tint_layer6", 32'({red, green, blue}), 32'h0F0);
        set_px(8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
        pixel(); pixel();
        check("tint_blank", 32'({red, green, blue}), 32'h000);
        bg_tint = 1'b0;
`endif

        // Randomized traffic against the model
        for (int it = 0; it < 400; it++) begin
            layer_hit = 8'($urandom);
            layer_en = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            blank = ($urandom_range(0, 7) == 0);
            outside = ($urandom_range(0, 2) == 0);
            transparent_outside = 1'($urandom_range(0, 1));
            flash_layer = 3'($urandom);
`ifdef LAYER_COMPOSITOR_BG_TINT_EN
            bg_tint = 1'($urandom_range(0, 1));
`endif
            if ($urandom_range(0, 9) == 0) begin
                cfg_we = 1'b1;
                cfg_addr = 4'($urandom);
                cfg_data = 12'($urandom);
            end
            step(1'b1, $urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0);
            repeat ($urandom_range(0, 3)) step(1'b0, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
